// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of a byte-lane data RAM interface.
// Takes one load/store request at a time from the memory stage. It drives per-lane
// enables and write strobes into WidthData/8 byte-wide RAM lanes, each with one-cycle
// registered read latency. Load data is aligned and sign/zero-extended, and every
// access finishes with a one-cycle Done pulse.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : a misaligned offset, or Size=11 when WidthData=32, completes at once as
//               Error+Done with no lane activity.
//   undefined : offsets are forced to natural alignment, Size=11 on a 32-bit path is
//               treated as word, and Error is always 0.
//
// Ports:
//   CLK, RST      clock; synchronous active-high reset
//   Request       start an access (sampled only in IDLE)
//   Write         1 = store, 0 = load
//   Size          00 byte, 01 half, 10 word, 11 doubleword
//   Unsigned      1 = zero-extend load, 0 = sign-extend
//   AddressIn     byte address
//   StoreData     right-justified store value
//   Busy          high whenever the FSM is not IDLE
//   Done, Error   completion pulse and its error qualifier
//   LoadResult    extended load data, held until the next load completes
//   RAMEnable     per-lane enable (registered)
//   WriteMemory   per-lane write strobe (registered)
//   Address       word address to all lanes (registered)
//   LoadData      store data shifted onto its lanes (registered)
//   OutputRAMMEM  concatenated lane read data
module mem_access_ctrl #(
  parameter int unsigned WidthData     = 32,
  parameter int unsigned RAM_ADDR_BITS = 4,
  parameter int unsigned ADDR_WIDTH    = RAM_ADDR_BITS + $clog2(WidthData / 8)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Request,
  input  logic                     Write,
  input  logic [1:0]               Size,
  input  logic                     Unsigned,
  input  logic [ADDR_WIDTH-1:0]    AddressIn,
  input  logic [WidthData-1:0]     StoreData,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic [WidthData-1:0]     LoadResult,
  output logic [WidthData/8-1:0]   RAMEnable,
  output logic [WidthData/8-1:0]   WriteMemory,
  output logic [RAM_ADDR_BITS-1:0] Address,
  output logic [WidthData-1:0]     LoadData,
  input  logic [WidthData-1:0]     OutputRAMMEM
);

  localparam int unsigned LANES    = WidthData / 8;
  localparam int unsigned OFF_BITS = $clog2(LANES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]               r_state;
  logic                     r_write;
  logic                     r_unsigned;
  logic                     r_err;
  logic [1:0]               r_size;
  logic [OFF_BITS-1:0]      r_off;
  logic [LANES-1:0]         r_ram_en;
  logic [LANES-1:0]         r_wr_mem;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [WidthData-1:0]     r_ld_data;
  logic [WidthData-1:0]     r_load_result;

  logic [1:0]               w_size_eff;
  logic [OFF_BITS-1:0]      w_off_raw;
  logic [OFF_BITS-1:0]      w_align;
  logic [OFF_BITS-1:0]      w_off;
  logic                     w_illegal;
  logic [31:0]              w_nbytes;
  logic [LANES-1:0]         w_mask;
  logic [WidthData-1:0]     w_store_shift;
  logic [WidthData-1:0]     w_rd_shift;
  logic [31:0]              w_nbits;
  logic                     w_sign;
  logic [WidthData-1:0]     w_load_ext;

  // Request decode: effective size, lane offset, legality and lane mask.
  always_comb begin
    w_size_eff = Size;
    // A 32-bit path has no doubleword; it collapses to word (rejected when checking).
    if (WidthData == 32 && Size == 2'b11) w_size_eff = 2'b10;
    w_off_raw = AddressIn[OFF_BITS-1:0];
    w_nbytes  = 32'd1 << w_size_eff;
    w_align   = OFF_BITS'(w_nbytes - 32'd1);
`ifdef MISALIGN_CHECK_EN
    w_off     = w_off_raw;
    w_illegal = ((w_off_raw & w_align) != '0) || (WidthData == 32 && Size == 2'b11);
`else
    w_off     = w_off_raw & ~w_align;
    w_illegal = 1'b0;
`endif
    w_mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_mask[i] = (i >= 32'(w_off)) && (i < 32'(w_off) + w_nbytes);
    end
    w_store_shift = StoreData << {w_off, 3'b000};
  end

  // Load alignment and extension of the captured lane data.
  always_comb begin
    w_rd_shift = OutputRAMMEM >> {r_off, 3'b000};
    w_nbits    = 32'd8 << r_size;
    if (w_nbits > WidthData) w_nbits = WidthData;
    w_sign = 1'b0;
    for (int unsigned i = 0; i < WidthData; i++) begin
      if (i == w_nbits - 32'd1) w_sign = w_rd_shift[i];
    end
    w_sign = w_sign & ~r_unsigned;
    w_load_ext = '0;
    for (int unsigned i = 0; i < WidthData; i++) begin
      w_load_ext[i] = (i < w_nbits) ? w_rd_shift[i] : w_sign;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_write       <= 1'b0;
      r_unsigned    <= 1'b0;
      r_err         <= 1'b0;
      r_size        <= 2'b00;
      r_off         <= '0;
      r_ram_en      <= '0;
      r_wr_mem      <= '0;
      r_addr        <= '0;
      r_ld_data     <= '0;
      r_load_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Request) begin
            r_write    <= Write;
            r_size     <= w_size_eff;
            r_unsigned <= Unsigned;
            r_off      <= w_off;
            if (w_illegal) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_ram_en  <= w_mask;
              r_wr_mem  <= Write ? w_mask : '0;
              r_addr    <= RAM_ADDR_BITS'(AddressIn >> OFF_BITS);
              r_ld_data <= w_store_shift;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_ram_en <= '0;
          r_wr_mem <= '0;
          r_state  <= r_write ? DONE : CAPTURE;
        end
        CAPTURE: begin
          r_load_result <= w_load_ext;
          r_state       <= DONE;
        end
        DONE: begin
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy        = (r_state != IDLE);
  assign Done        = (r_state == DONE);
  assign Error       = r_err;
  assign LoadResult  = r_load_result;
  assign RAMEnable   = r_ram_en;
  assign WriteMemory = r_wr_mem;
  assign Address     = r_addr;
  assign LoadData    = r_ld_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl (WidthData=32). A 4-lane byte RAM model sits on the memory
// side. A vector table drives single accesses, and a scoreboard queue checks
// Error/LoadResult on every Done pulse. Hand-written sequences cover a request held
// high across an access and a reset during CAPTURE.
module tb_mem_access_ctrl;

  localparam int unsigned WD  = 32;
  localparam int unsigned RAB = 4;
  localparam int unsigned AW  = 6;
  localparam int unsigned LN  = 4;

  logic          CLK;
  logic          RST;
  logic          Request;
  logic          Write;
  logic [1:0]    Size;
  logic          Unsigned;
  logic [AW-1:0] AddressIn;
  logic [WD-1:0] StoreData;
  logic          Busy;
  logic          Done;
  logic          Error;
  logic [WD-1:0] LoadResult;
  logic [LN-1:0] RAMEnable;
  logic [LN-1:0] WriteMemory;
  logic [RAB-1:0] Address;
  logic [WD-1:0] LoadData;
  logic [WD-1:0] OutputRAMMEM;

  mem_access_ctrl #(
    .WidthData    (WD),
    .RAM_ADDR_BITS(RAB),
    .ADDR_WIDTH   (AW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Request     (Request),
    .Write       (Write),
    .Size        (Size),
    .Unsigned    (Unsigned),
    .AddressIn   (AddressIn),
    .StoreData   (StoreData),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error),
    .LoadResult  (LoadResult),
    .RAMEnable   (RAMEnable),
    .WriteMemory (WriteMemory),
    .Address     (Address),
    .LoadData    (LoadData),
    .OutputRAMMEM(OutputRAMMEM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Byte-lane RAM model: registered read, output cleared when the lane is not enabled.
  logic [7:0] mem [LN][16];
  logic [7:0] rdq [LN];
  logic       mem_init;

  always @(posedge CLK) begin
    for (int i = 0; i < LN; i++) begin
      if (mem_init) begin
        for (int a = 0; a < 16; a++) mem[i][a] <= 8'h00;
        rdq[i] <= 8'h00;
      end else if (RAMEnable[i]) begin
        if (WriteMemory[i]) mem[i][Address] <= LoadData[8*i +: 8];
        rdq[i] <= mem[i][Address];
      end else begin
        rdq[i] <= 8'h00;
      end
    end
  end
  assign OutputRAMMEM = {rdq[3], rdq[2], rdq[1], rdq[0]};

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  addr;
    logic [31:0] sdata;
    logic        err;
    logic [3:0]  en;
    logic [31:0] ldata;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] res;
  } sb_t;

  int          n_checks;
  int          n_pass;
  logic [31:0] tb_last;
  sb_t         sb_q[$];
  sb_t         mon_e;
  vec_t        vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [5:0] a, input logic [31:0] sd, input logic err,
                              input logic [3:0] en, input logic [31:0] ld,
                              input logic [31:0] res);
    vec_t v;
    v.wr = wr; v.size = sz; v.uns = uns; v.addr = a; v.sdata = sd;
    v.err = err; v.en = en; v.ldata = ld; v.res = res;
    return v;
  endfunction

  // Scoreboard: every Done pulse consumes one expected completion.
  always @(negedge CLK) begin
    if (Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got Done=1 expected no completion");
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_error", 32'(Error), 32'(mon_e.err));
        check("sb_result", LoadResult, mon_e.res);
      end
    end
  end

  // Returns at the negedge where Done is seen; lat = edges after the sampling edge.
  task automatic wait_done(output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge CLK);
      if (Done === 1'b1) got = 1'b1;
      else begin
        @(posedge CLK);
        lat++;
      end
    end
    check("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int       lat;
    bit       got;
    sb_t      e;
    logic [3:0] exp_wr;
    @(negedge CLK);
    Write = v.wr; Size = v.size; Unsigned = v.uns; AddressIn = v.addr;
    StoreData = v.sdata; Request = 1'b1;
    e.err = v.err;
    e.res = (!v.wr && !v.err) ? v.res : tb_last;
    tb_last = e.res;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    Request = 1'b0;
    exp_wr = v.wr ? v.en : 4'h0;
    check($sformatf("v%0d_busy", k), 32'(Busy), 32'd1);
    check($sformatf("v%0d_ramen", k), 32'(RAMEnable), 32'(v.en));
    check($sformatf("v%0d_wrmem", k), 32'(WriteMemory), 32'(exp_wr));
    if (!v.err) check($sformatf("v%0d_addr", k), 32'(Address), 32'(v.addr >> 2));
    if (v.wr && !v.err) check($sformatf("v%0d_ldata", k), LoadData, v.ldata);
    wait_done(lat, got);
    check($sformatf("v%0d_latency", k), 32'(lat), v.err ? 32'd0 : (v.wr ? 32'd1 : 32'd2));
    @(posedge CLK);
    #1;
    check($sformatf("v%0d_pulse", k), 32'(Done), 32'd0);
    check($sformatf("v%0d_idle", k), 32'(Busy), 32'd0);
    check($sformatf("v%0d_en_off", k), 32'(RAMEnable), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  got;
    sb_t e;
    n_checks = 0; n_pass = 0; tb_last = 32'h0;
    RST = 1'b1; mem_init = 1'b1; Request = 1'b0; Write = 1'b0; Size = 2'b00;
    Unsigned = 1'b0; AddressIn = '0; StoreData = '0;

    vecs[0]  = mk(1, 2'b10, 0, 6'h08, 32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 0);
    vecs[1]  = mk(0, 2'b00, 0, 6'h0B, 0, 0, 4'h8, 0, 32'hFFFFFFDE);
    vecs[2]  = mk(0, 2'b00, 1, 6'h0B, 0, 0, 4'h8, 0, 32'h000000DE);
    vecs[3]  = mk(1, 2'b01, 0, 6'h0A, 32'h00001234, 0, 4'hC, 32'h12340000, 0);
    vecs[4]  = mk(0, 2'b10, 0, 6'h08, 0, 0, 4'hF, 0, 32'h1234BEEF);
    vecs[5]  = mk(0, 2'b01, 0, 6'h08, 0, 0, 4'h3, 0, 32'hFFFFBEEF);
    vecs[6]  = mk(0, 2'b01, 1, 6'h0A, 0, 0, 4'hC, 0, 32'h00001234);
    vecs[7]  = mk(1, 2'b00, 0, 6'h01, 32'h000000A5, 0, 4'h2, 32'h0000A500, 0);
    vecs[8]  = mk(0, 2'b00, 0, 6'h01, 0, 0, 4'h2, 0, 32'hFFFFFFA5);
    vecs[9]  = mk(0, 2'b10, 0, 6'h00, 0, 0, 4'hF, 0, 32'h0000A500);
    vecs[10] = mk(1, 2'b10, 0, 6'h04, 32'h0BADF00D, 0, 4'hF, 32'h0BADF00D, 0);
    vecs[14] = mk(0, 2'b01, 0, 6'h04, 0, 0, 4'h3, 0, 32'hFFFFF00D);
    vecs[17] = mk(0, 2'b00, 1, 6'h09, 0, 0, 4'h2, 0, 32'h000000BE);
`ifdef MISALIGN_CHECK_EN
    vecs[11] = mk(0, 2'b10, 0, 6'h05, 0, 1, 4'h0, 0, 0);
    vecs[12] = mk(0, 2'b11, 0, 6'h04, 0, 1, 4'h0, 0, 0);
    vecs[13] = mk(0, 2'b01, 0, 6'h07, 0, 1, 4'h0, 0, 0);
    vecs[15] = mk(1, 2'b01, 0, 6'h03, 32'h0000CAFE, 1, 4'h0, 0, 0);
    vecs[16] = mk(0, 2'b10, 0, 6'h00, 0, 0, 4'hF, 0, 32'h0000A500);
`else
    vecs[11] = mk(0, 2'b10, 0, 6'h05, 0, 0, 4'hF, 0, 32'h0BADF00D);
    vecs[12] = mk(0, 2'b11, 0, 6'h04, 0, 0, 4'hF, 0, 32'h0BADF00D);
    vecs[13] = mk(0, 2'b01, 0, 6'h07, 0, 0, 4'hC, 0, 32'h00000BAD);
    vecs[15] = mk(1, 2'b01, 0, 6'h03, 32'h0000CAFE, 0, 4'hC, 32'hCAFE0000, 0);
    vecs[16] = mk(0, 2'b10, 0, 6'h00, 0, 0, 4'hF, 0, 32'hCAFEA500);
`endif
    vecs[18] = mk(0, 2'b01, 1, 6'h0E, 0, 0, 4'hC, 0, 32'h00000000);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mem_init = 1'b0;
    @(negedge CLK);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_result", LoadResult, 32'd0);
    check("rst_ramen", 32'(RAMEnable), 32'd0);
    check("rst_wrmem", 32'(WriteMemory), 32'd0);
    check("rst_addr", 32'(Address), 32'd0);
    check("rst_ldata", LoadData, 32'd0);

    for (int k = 0; k < 19; k++) run_vec(vecs[k], k);

    // Request held high: second access accepted only in IDLE after Done.
    @(negedge CLK);
    Write = 1'b0; Size = 2'b10; Unsigned = 1'b0; AddressIn = 6'h08; Request = 1'b1;
    e.err = 1'b0; e.res = 32'h1234BEEF; tb_last = e.res;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check("held_first_en", 32'(RAMEnable), 32'hF);
    wait_done(lat, got);
    check("held_latency", 32'(lat), 32'd2);
    @(posedge CLK);
    #1;
    check("held_gap_idle", 32'(Busy), 32'd0);
    check("held_gap_en", 32'(RAMEnable), 32'd0);
    @(posedge CLK);
    #1;
    check("held_reaccept_busy", 32'(Busy), 32'd1);
    check("held_reaccept_en", 32'(RAMEnable), 32'hF);
    Request = 1'b0;
    @(posedge CLK);
    #1;
    check("capture_busy", 32'(Busy), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tb_last = 32'h0;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_result", LoadResult, 32'd0);
    check("midrst_ramen", 32'(RAMEnable), 32'd0);
    repeat (3) begin
      @(negedge CLK);
      check("midrst_no_done", 32'(Done), 32'd0);
    end

    // Memory contents survive the controller reset.
    run_vec(mk(0, 2'b10, 0, 6'h08, 0, 0, 4'hF, 0, 32'h1234BEEF), 19);

    repeat (3) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the byte-lane data RAM interface.
- Accepts one load/store request at a time from the processor's memory stage and splits it into per-lane enable and write strobes for a bank of WidthData/8 byte-wide RAM lanes.
- Each lane has one-cycle registered read latency, and its output is forced to 0 when its enable is low.
- Aligns and extends load data, then returns it with a one-cycle Done pulse.

Parameters:
- WidthData, 32, data path width; 32 or 64; lane count LANES = WidthData/8.
- RAM_ADDR_BITS, 4, word-address width presented to every lane.
- ADDR_WIDTH, RAM_ADDR_BITS+log2(LANES), byte-address width on the processor side.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- Request  in  1  start access; sampled only in IDLE
- Write  in  1  1=store, 0=load
- Size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when WidthData=64)
- Unsigned  in  1  load zero-extends when 1, sign-extends when 0
- AddressIn  in  ADDR_WIDTH  byte address
- StoreData  in  WidthData  store value, right-justified
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle completion pulse
- Error  out  1  valid with Done; misaligned or illegal size
- LoadResult  out  WidthData  extended load data; holds until next load completes
- RAMEnable  out  LANES  per-lane enable, registered
- WriteMemory  out  LANES  per-lane write strobe, registered
- Address  out  RAM_ADDR_BITS  word address = AddressIn >> log2(LANES), registered
- LoadData  out  WidthData  store data shifted to lane position; lane i = bits [8i+7:8i], registered
- OutputRAMMEM  in  WidthData  concatenated lane outputs, same lane mapping

Behaviour:
- Reset values: state IDLE; Busy, Done, Error, RAMEnable, WriteMemory, Address, LoadData and LoadResult all 0.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE with Request=1 at edge E0:
  - Latch Write, Size, Unsigned and the lane offset (AddressIn low log2(LANES) bits).
  - If the access is illegal -> DONE with Error=1, no lane enabled.
  - Otherwise -> ISSUE and register the memory-side outputs.
- Lane mask:
  - Byte: 1 lane at offset.
  - Half: 2 lanes from offset.
  - Word: 4 lanes from offset.
  - Doubleword: all 8 lanes.
  - WriteMemory = mask when Write=1, else 0.
- ISSUE (E0..E1): RAMEnable = mask. At E1: store -> DONE; load -> CAPTURE. RAMEnable and WriteMemory return to 0 at E1.
- CAPTURE (E1..E2): OutputRAMMEM carries the read data. At E2:
  - Shift the data right by offset*8 and mask to Size.
  - Extend per Unsigned into LoadResult.
  - -> DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Error=0 except the illegal-access case. Busy drops when the state returns to IDLE.
- Latency from the sampling edge E0 to Done high:
  - Load: Done high between E2 and E3.
  - Store: Done high between E1 and E2.
  - Error: Done high between E0 and E1.
- Request while Busy: ignored, not queued. It may be re-sampled in IDLE on the cycle after Done.
- LoadResult is unchanged by stores and errors.
- RST mid-operation: next edge -> IDLE. Enables and strobes go to 0, no Done is issued, and LoadResult is cleared. A write already registered on that edge cannot be revoked.
- Lanes outside the mask are never enabled, so unselected bytes are never corrupted.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - Illegal access = offset not a multiple of the access size, or Size=11 when WidthData=32.
  - It completes as Error+Done after 1 cycle with no memory activity.
- Not defined:
  - Offset low bits are forced to natural alignment (half: bit0=0; word: bits[1:0]=0).
  - Size=11 with WidthData=32 is treated as word.
  - The access proceeds normally and Error is tied 0.

Test Plan:
1. RST high 2 cycles, then low -> all outputs 0, Busy=0.
2. Word store, AddressIn=0x08, StoreData=0xDEADBEEF (WidthData=32) ->
   - ISSUE: RAMEnable=1111, WriteMemory=1111, Address=2, LoadData=0xDEADBEEF.
   - Done 1 cycle after ISSUE, Error=0.
3. Signed byte load from AddressIn=0x0B after test 2 -> RAMEnable=1000 only; LoadResult=0xFFFFFFDE with Done at E2+. Same load with Unsigned=1 -> 0x000000DE.
4. Half store 0x1234 to AddressIn=0x0A, then word load from 0x08 -> LoadResult=0x1234BEEF; lanes 0-1 untouched.
5. With MISALIGN_CHECK_EN, word load from AddressIn=0x05 -> Done and Error high the cycle after request, RAMEnable never asserted, LoadResult unchanged. Without the macro -> word read from word address 1.
6. Request held high through a load, plus RST asserted during CAPTURE -> second request accepted only after Done; on reset the state is IDLE next cycle with no Done pulse and LoadResult=0.
